// File: rtl/if_decoder.sv
// if_decoder: receiving end of the instruction-fetch interface.
// Decodes V850 format I / II / VI integer instructions into ALU-op, register
// and immediate fields, queued through a 2-entry registered output buffer.
// Optional statistics counters: define IF_DECODER_STATS_EN.
module if_decoder #(
    parameter int PC_W   = 25,
    parameter int INST_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [INST_W-1:0] instruction_i,
    input  logic [1:0]        inst_len_i,
    input  logic [PC_W-1:0]   PC_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [2:0]        op_o,
    output logic              use_imm_o,
    output logic [4:0]        reg1_o,
    output logic [4:0]        reg2_o,
    output logic [31:0]       imm_o,
    output logic              wb_en_o,
    output logic              illegal_o,
    output logic [PC_W-1:0]   PC_o
`ifdef IF_DECODER_STATS_EN
    ,
    output logic [31:0]       dec_count_o,
    output logic [15:0]       illegal_count_o
`endif
);

    localparam logic [2:0] OP_MOV = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2, OP_CMP = 3'd3,
                           OP_AND = 3'd4, OP_OR  = 3'd5, OP_XOR = 3'd6;

    typedef struct packed {
        logic [2:0]      op;
        logic            use_imm;
        logic [4:0]      reg1;
        logic [4:0]      reg2;
        logic [31:0]     imm;
        logic            wb_en;
        logic            illegal;
        logic [PC_W-1:0] pc;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t state, state_nx;
    entry_t slot0, slot1, dec;
    logic   push, pop, load0, load1, shift;
    logic   legal;
    logic [15:0] h, s;
    logic [5:0]  opc;

    // Bits above the second halfword carry no supported encoding.
    logic unused_hi;
    assign unused_hi = ^instruction_i[INST_W-1:32];

    // Decode the presented instruction; illegal encodings clear op/imm fields.
    always_comb begin
        dec   = '0;
        legal = 1'b1;
        h     = (inst_len_i == 2'd1) ? instruction_i[31:16] : instruction_i[15:0];
        s     = instruction_i[15:0];
        opc   = h[10:5];
        dec.reg2 = h[15:11];
        dec.reg1 = h[4:0];
        dec.pc   = PC_i;
        case (inst_len_i)
            2'd0: begin
                case (opc)
                    6'b000000: dec.op = OP_MOV;
                    6'b001110: dec.op = OP_ADD;
                    6'b001101: dec.op = OP_SUB;
                    6'b001111: dec.op = OP_CMP;
                    6'b001010: dec.op = OP_AND;
                    6'b001000: dec.op = OP_OR;
                    6'b001001: dec.op = OP_XOR;
                    6'b010000, 6'b010010, 6'b010011: begin
                        dec.op      = (opc == 6'b010000) ? OP_MOV :
                                      (opc == 6'b010010) ? OP_ADD : OP_CMP;
                        dec.use_imm = 1'b1;
                        dec.imm     = {{27{h[4]}}, h[4:0]};
                    end
                    default: legal = 1'b0;
                endcase
            end
            2'd1: begin
                dec.use_imm = 1'b1;
                case (opc)
                    6'b110110: begin dec.op = OP_AND; dec.imm = {16'h0, s}; end
                    6'b110100: begin dec.op = OP_OR;  dec.imm = {16'h0, s}; end
                    6'b110101: begin dec.op = OP_XOR; dec.imm = {16'h0, s}; end
                    6'b110000, 6'b110001: begin
                        dec.op  = OP_ADD;
                        dec.imm = {{16{s[15]}}, s};
                    end
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec.op      = OP_MOV;
            dec.use_imm = 1'b0;
            dec.imm     = '0;
        end
        dec.illegal = ~legal;
        dec.wb_en   = legal && (dec.op != OP_CMP) && (dec.reg2 != 5'd0);
    end

    // Buffer occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nx;
    end

    // Next occupancy, handshake and slot-load controls.
    always_comb begin
        in_ready_o  = (state != FULL);
        out_valid_o = (state != EMPTY);
        push  = in_valid_i && in_ready_o;
        pop   = out_valid_o && out_ready_i;
        load0 = push && ((state == EMPTY) || (state == ONE && pop));
        load1 = push && (state == ONE) && !pop;
        shift = pop && (state == FULL);
        state_nx = state;
        case (state)
            EMPTY:   if (push) state_nx = ONE;
            ONE:     if (push && !pop) state_nx = FULL;
                     else if (!push && pop) state_nx = EMPTY;
            FULL:    if (pop) state_nx = ONE;
            default: state_nx = EMPTY;
        endcase
        if (flush_i) state_nx = EMPTY;
    end

    // Entry storage: slot0 is always the head presented to execute.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            if (load0)      slot0 <= dec;
            else if (shift) slot0 <= slot1;
            if (load1)      slot1 <= dec;
        end
    end

    assign op_o      = slot0.op;
    assign use_imm_o = slot0.use_imm;
    assign reg1_o    = slot0.reg1;
    assign reg2_o    = slot0.reg2;
    assign imm_o     = slot0.imm;
    assign wb_en_o   = slot0.wb_en;
    assign illegal_o = slot0.illegal;
    assign PC_o      = slot0.pc;

`ifdef IF_DECODER_STATS_EN
    // Pop counters; the illegal count saturates, the total wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_count_o     <= '0;
            illegal_count_o <= '0;
        end else if (pop) begin
            dec_count_o <= dec_count_o + 32'd1;
            if (slot0.illegal && illegal_count_o != 16'hFFFF)
                illegal_count_o <= illegal_count_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_decoder.sv
// Self-checking bench for if_decoder: queue-based reference model, per-cycle
// compare process, directed literal checks and a randomized phase.
module tb_if_decoder;
    logic        clk = 0, rst_n = 0, flush_i = 0, in_valid_i = 0, out_ready_i = 0;
    logic        in_ready_o, out_valid_o, use_imm_o, wb_en_o, illegal_o;
    logic [63:0] instruction_i = '0;
    logic [1:0]  inst_len_i = '0;
    logic [24:0] PC_i = '0, PC_o;
    logic [2:0]  op_o;
    logic [4:0]  reg1_o, reg2_o;
    logic [31:0] imm_o;
`ifdef IF_DECODER_STATS_EN
    logic [31:0] dec_count_o;
    logic [15:0] illegal_count_o;
`endif

    if_decoder #(.PC_W(25), .INST_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o), .instruction_i(instruction_i), .inst_len_i(inst_len_i),
        .PC_i(PC_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .op_o(op_o),
        .use_imm_o(use_imm_o), .reg1_o(reg1_o), .reg2_o(reg2_o), .imm_o(imm_o),
        .wb_en_o(wb_en_o), .illegal_o(illegal_o), .PC_o(PC_o)
`ifdef IF_DECODER_STATS_EN
        , .dec_count_o(dec_count_o), .illegal_count_o(illegal_count_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic        ui;
        logic [4:0]  r1, r2;
        logic [31:0] imm;
        logic        wb, ill;
        logic [24:0] pc;
    } ent_t;

    // Supported encodings: opcode, length, ALU op, immediate kind
    // (0 none, 1 signed 5-bit reg1 field, 2 zero-ext S, 3 sign-ext S).
    int T_OPC [15] = '{'h00, 'h0E, 'h0D, 'h0F, 'h0A, 'h08, 'h09, 'h10, 'h12, 'h13,
                       'h36, 'h34, 'h35, 'h30, 'h31};
    int T_LEN [15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    int T_OP  [15] = '{0, 1, 2, 3, 4, 5, 6, 0, 1, 3, 4, 5, 6, 1, 1};
    int T_EXT [15] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3};

    ent_t q[$];
    int   n_chk = 0, n_fail = 0;
    int   m_dec = 0, m_ill = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic ent_t mdec(input logic [63:0] ins, input logic [1:0] len,
                                  input logic [24:0] pc);
        ent_t e;
        logic [15:0] h, s;
        int v;
        h = (len == 2'd1) ? ins[31:16] : ins[15:0];
        s = ins[15:0];
        e.r2 = h[15:11]; e.r1 = h[4:0]; e.pc = pc;
        e.op = 0; e.ui = 0; e.imm = 0; e.ill = 1; e.wb = 0;
        for (int i = 0; i < 15; i++) begin
            if (T_OPC[i] == int'(h[10:5]) && T_LEN[i] == int'(len)) begin
                e.ill = 0;
                e.op  = 3'(T_OP[i]);
                e.ui  = (T_EXT[i] != 0);
                case (T_EXT[i])
                    1: begin v = int'(h[4:0]); if (v > 15) v -= 32; e.imm = v; end
                    2: e.imm = {16'h0, s};
                    3: begin v = int'(s); if (v > 32767) v -= 65536; e.imm = v; end
                    default: e.imm = 0;
                endcase
            end
        end
        if (!e.ill) e.wb = (e.op != 3) && (e.r2 != 0);
        return e;
    endfunction

    // Reference model: transaction-level FIFO of decoded entries.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_dec = 0;
            m_ill = 0;
        end else begin
            automatic bit pop  = (q.size() > 0) && out_ready_i;
            automatic bit push = in_valid_i && (q.size() < 2);
            if (pop) begin
                m_dec++;
                if (q[0].ill && m_ill < 65535) m_ill++;
                void'(q.pop_front());
            end
            if (flush_i) q.delete();
            else if (push) q.push_back(mdec(instruction_i, inst_len_i, PC_i));
        end
    end

    // Compare DUT against the model on every falling edge out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", out_valid_o, q.size() > 0);
            chk("in_ready", in_ready_o, q.size() < 2);
            if (q.size() > 0) begin
                chk("op", op_o, q[0].op);
                chk("use_imm", use_imm_o, q[0].ui);
                chk("reg1", reg1_o, q[0].r1);
                chk("reg2", reg2_o, q[0].r2);
                chk("imm", imm_o, q[0].imm);
                chk("wb_en", wb_en_o, q[0].wb);
                chk("illegal", illegal_o, q[0].ill);
                chk("pc", PC_o, q[0].pc);
            end
`ifdef IF_DECODER_STATS_EN
            chk("dec_count", dec_count_o, m_dec);
            chk("illegal_count", illegal_count_o, m_ill);
`endif
        end
    end

    // Present one instruction for exactly one cycle, then leave outputs to settle.
    task automatic push1(input logic [63:0] ins, input logic [1:0] len, input logic [24:0] pc);
        @(negedge clk); #1;
        in_valid_i = 1; instruction_i = ins; inst_len_i = len; PC_i = pc;
        @(negedge clk); #1;
        in_valid_i = 0;
    endtask

    task automatic rand_inst();
        logic [5:0]  opc;
        logic [15:0] h;
        int r;
        r = $urandom_range(0, 19);
        opc = (r < 15) ? 6'(T_OPC[r]) : 6'($urandom);
        h = 16'($urandom);
        h[10:5] = opc;
        r = $urandom_range(0, 19);
        inst_len_i = (r < 9) ? 2'd0 : (r < 18) ? 2'd1 : 2'($urandom_range(2, 3));
        instruction_i = {$urandom, $urandom};
        if (inst_len_i == 2'd1) instruction_i[31:16] = h;
        else                    instruction_i[15:0]  = h;
        PC_i = 25'($urandom);
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst out_valid", out_valid_o, 0);
        chk("rst in_ready", in_ready_o, 1);
        chk("rst op", op_o, 0);
        chk("rst imm", imm_o, 0);
        chk("rst pc", PC_o, 0);
        chk("rst illegal", illegal_o, 0);
        #10 rst_n = 1;
        out_ready_i = 1;

        // Format I ADD
        push1(64'h11C1, 0, 25'h10);
        chk("addr op", op_o, 1); chk("addr reg2", reg2_o, 2); chk("addr reg1", reg1_o, 1);
        chk("addr use_imm", use_imm_o, 0); chk("addr wb", wb_en_o, 1);
        chk("addr illegal", illegal_o, 0); chk("addr pc", PC_o, 25'h10);
        // CMP: no writeback
        push1(64'h49E1, 0, 25'h14);
        chk("cmp op", op_o, 3); chk("cmp reg2", reg2_o, 9); chk("cmp wb", wb_en_o, 0);
        // Format VI opcode with 16-bit length is illegal
        push1(64'h1EC1, 0, 25'h18);
        chk("ill flag", illegal_o, 1); chk("ill wb", wb_en_o, 0);
        chk("ill op", op_o, 0); chk("ill pc", PC_o, 25'h18);
        @(negedge clk);
`ifdef IF_DECODER_STATS_EN
        #1;
        chk("stats dec", dec_count_o, 3);
        chk("stats ill", illegal_count_o, 1);
`endif
        // Format II ADD with negative immediate
        push1(64'h125F, 0, 25'h1C);
        chk("addi5 op", op_o, 1); chk("addi5 use_imm", use_imm_o, 1);
        chk("addi5 imm", imm_o, 32'hFFFFFFFF); chk("addi5 wb", wb_en_o, 1);
        // Format VI ANDI, zero-extended immediate
        push1(64'h1EC1000B, 1, 25'h20);
        chk("andi op", op_o, 4); chk("andi reg2", reg2_o, 3); chk("andi reg1", reg1_o, 1);
        chk("andi imm", imm_o, 32'h0000000B);
        push1(64'h1EC18000, 1, 25'h24);
        chk("andi imm hi", imm_o, 32'h00008000);

        // Backpressure: three back-to-back pushes, third held while full
        @(negedge clk); #1;
        out_ready_i = 0;
        in_valid_i = 1; instruction_i = 64'h11C1; inst_len_i = 0; PC_i = 25'h100;
        @(negedge clk); #1; PC_i = 25'h104;
        @(negedge clk); #1; PC_i = 25'h108;
        chk("bp in_ready low", in_ready_o, 0);
        @(negedge clk); #1;
        chk("bp held", in_ready_o, 0);
        out_ready_i = 1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        in_valid_i = 0;
        repeat (4) @(negedge clk);

        // Flush while full with a push pending
        #1; out_ready_i = 0; in_valid_i = 1; PC_i = 25'h200;
        @(negedge clk); #1; PC_i = 25'h204;
        @(negedge clk); #1; PC_i = 25'h208; flush_i = 1;
        @(negedge clk); #1;
        flush_i = 0; in_valid_i = 0;
        chk("flush out_valid", out_valid_o, 0);
        chk("flush in_ready", in_ready_o, 1);
        out_ready_i = 1;

        // Reset mid-operation
        @(negedge clk); #1; out_ready_i = 0; in_valid_i = 1; PC_i = 25'h300;
        @(negedge clk); #1; in_valid_i = 0;
        rst_n = 0; #1;
        chk("midrst out_valid", out_valid_o, 0);
        chk("midrst in_ready", in_ready_o, 1);
        chk("midrst pc", PC_o, 0);
        @(negedge clk); #1; rst_n = 1;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #1;
            in_valid_i  = ($urandom_range(0, 3) != 0);
            out_ready_i = ($urandom_range(0, 2) != 0);
            flush_i     = ($urandom_range(0, 39) == 0);
            rand_inst();
        end
        @(negedge clk); #1;
        in_valid_i = 0; flush_i = 0; out_ready_i = 1;
        repeat (4) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/if_decoder.md
Name: if_decoder

Overview:
- Receiving end of the instruction-fetch interface: accepts fetched instruction words with their PC from the fetcher and decodes V850 format I, II and VI integer instructions into register, operand and ALU-op fields for execute.
- Sits between the fetcher and execute.
- Uses a 2-entry output buffer with valid/ready on both sides, so in_ready_o never depends combinationally on out_ready_i.

Parameters:
- PC_W, 25, width of PC_i / PC_o.
- INST_W, 64, width of instruction_i.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush_i  input  1  synchronous flush; discards all buffered entries.
- in_valid_i  input  1  fetcher presents an instruction.
- in_ready_o  output  1  decoder can accept this cycle.
- instruction_i  input  INST_W  fetched bits; first halfword in the top valid halfword (see Behaviour).
- inst_len_i  input  2  0=16b, 1=32b, 2=48b, 3=64b.
- PC_i  input  PC_W  address of the instruction.
- out_valid_o  output  1  decoded entry available.
- out_ready_i  input  1  execute accepts the entry.
- op_o  output  3  0 MOV, 1 ADD, 2 SUB, 3 CMP, 4 AND, 5 OR, 6 XOR.
- use_imm_o  output  1  operand 1 is imm_o instead of reg1.
- reg1_o  output  5  source register field.
- reg2_o  output  5  source/destination register field.
- imm_o  output  32  extended immediate.
- wb_en_o  output  1  result written to reg2.
- illegal_o  output  1  unsupported encoding or length.
- PC_o  output  PC_W  PC of the entry.

Behaviour:
- Reset (rst_n=0, async): buffer EMPTY. Outputs: out_valid_o=0, in_ready_o=1, all data outputs 0.
- Buffer states and in_ready_o:
  - EMPTY (count 0): in_ready_o=1.
  - ONE (count 1): in_ready_o=1.
  - FULL (count 2): in_ready_o=0.
- Handshake: accept when in_valid_i&&in_ready_o; pop when out_valid_o&&out_ready_i. Simultaneous push and pop leaves the count unchanged; order preserved FIFO.
- Latency: an accepted instruction appears on the outputs the following cycle. Output fields are registered and stay stable while out_valid_o=1 and out_ready_i=0.
- flush_i: next state EMPTY regardless of push/pop that cycle; any push in a flush cycle is dropped.
- First halfword location H, set by inst_len_i:
  - len 0: H=[15:0].
  - len 1: H=[31:16], second halfword S=[15:0].
  - len 2/3: decoded as illegal.
- Field extraction from H: reg2=H[15:11], opcode=H[10:5], reg1=H[4:0].
- Format I, len 0, use_imm=0:
  - 000000 MOV, 001110 ADD, 001101 SUB, 001111 CMP, 001010 AND, 001000 OR, 001001 XOR.
- Format II, len 0, use_imm=1, imm_o = sign-extended H[4:0]:
  - 010000 MOV, 010010 ADD, 010011 CMP.
- Format VI, len 1, use_imm=1:
  - 110110 ANDI (AND), 110100 ORI (OR), 110101 XORI (XOR): imm_o = zero-extended S.
  - 110000 ADDI (ADD), 110001 MOVEA (ADD): imm_o = sign-extended S.
- wb_en_o: 1 except for CMP, illegal entries, or reg2=0 (r0 hardwired).
- Illegal cases: any other opcode/length pair, including a format VI opcode with len 0 or a format I opcode with len 1. Result: illegal_o=1, wb_en_o=0, op_o=0, use_imm_o=0, imm_o=0; reg fields and PC passed through.
- Reset mid-operation: all entries lost, outputs return to reset values immediately.

Optional Feature:
- Macro: IF_DECODER_STATS_EN.
- Enabled: adds output dec_count_o[31:0] and illegal_count_o[15:0].
  - dec_count_o increments on every pop; illegal_count_o increments on every pop with illegal_o=1.
  - illegal_count_o saturates at 16'hFFFF; dec_count_o wraps.
  - Both counters reset to 0 on rst_n, unaffected by flush_i.
- Disabled: ports and counters absent; all other behaviour identical.

Test Plan:
- instruction_i=0x11C1, len=0, PC=0x10, out_ready=1 -> next cycle op=ADD, reg2=2, reg1=1, use_imm=0, wb_en=1, illegal=0, PC_o=0x10.
- instruction_i=0x125F, len=0 -> op=ADD, reg2=2, use_imm=1, imm_o=0xFFFFFFFF, wb_en=1.
- instruction_i=0x1EC1000B, len=1 -> op=AND, reg2=3, reg1=1, use_imm=1, imm_o=0x0000000B; repeat with S=0x8000 -> imm_o=0x00008000.
- instruction_i=0x49E1, len=0 -> op=CMP, reg2=9, reg1=1, wb_en=0; then 0x1EC1, len=0 -> illegal=1, wb_en=0.
- out_ready=0, push 3 back-to-back -> in_ready_o falls to 0 after 2 accepts, third held; release out_ready -> all 3 emerge in order, none lost or duplicated.
- Buffer FULL, assert flush_i with in_valid=1 -> next cycle out_valid=0, in_ready=1, no entry emerges; with IF_DECODER_STATS_EN, 3 pops incl. 1 illegal -> dec_count=3, illegal_count=1.
